// File: rtl/wb_uart_bridge.sv
// wb_uart_bridge: Wishbone classic slave feeding UartTop.
// Bus writes go into a TX FIFO that a small FSM hands to UartTop over its
// valid/busy handshake. Received bytes land in a one-deep holding register.
// Optional feature macro: WB_UART_IRQ_EN adds the irq output and the
// interrupt-enable bits in CTRL.
//
// Handshakes:
//  - Wishbone: a request is cyc & stb & !ack. ack is registered one cycle
//    after the request and lasts exactly one cycle. Every side effect
//    (push, pop, flag clear) happens on the edge that registers ack.
//  - UartTop TX: in PRESENT, uart_tx_valid follows uart_tx_busy
//    combinationally. A cycle with busy low is the acceptance, and valid
//    drops in that same cycle so one byte can never be taken twice.
//  - UartTop RX: uart_rx_valid is a one-cycle pulse per received byte.
module wb_uart_bridge #(
  parameter int TX_FIFO_DEPTH = 16,
  parameter int TX_AW         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [1:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_valid,
  input  logic       uart_tx_busy,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_valid,
`ifdef WB_UART_IRQ_EN
  output logic       irq,
`endif
  output logic [1:0] dbg_tx_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_GAP     = 2'd2
  } tx_state_t;

  localparam logic [TX_AW:0]   FULL_CNT = (TX_AW+1)'(TX_FIFO_DEPTH);
  localparam logic [TX_AW:0]   CNT_ONE  = (TX_AW+1)'(1);
  localparam logic [TX_AW-1:0] PTR_ONE  = TX_AW'(1);

  tx_state_t state, state_n;

  logic [7:0]       mem [TX_FIFO_DEPTH];
  logic [TX_AW-1:0] wr_ptr, rd_ptr;
  logic [TX_AW:0]   count;
  logic             tx_full, tx_empty, tx_active;
  logic             tx_push_req, tx_push, tx_pop;

  logic       rx_full, rx_overrun, tx_overflow;
  logic [7:0] rx_data;

  logic       req, wr, rd, ctrl_wr, rx_pop;
  logic [7:0] rd_mux, status, ctrl_rd;

  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = req & wb_we_i;
  assign rd      = req & ~wb_we_i;
  assign ctrl_wr = wr & (wb_adr_i == 2'd3);
  assign rx_pop  = rd & (wb_adr_i == 2'd1) & rx_full;

  assign tx_full     = (count == FULL_CNT);
  assign tx_empty    = (count == '0);
  assign tx_active   = (state != S_IDLE);
  assign tx_push_req = wr & (wb_adr_i == 2'd0);
  assign tx_push     = tx_push_req & ~tx_full;

  assign status       = {2'b00, tx_active, tx_overflow, rx_overrun, rx_full, tx_empty, tx_full};
  assign dbg_tx_state = state;

  // Register read mux, sampled on the request cycle
  always_comb begin
    rd_mux = 8'h00;
    case (wb_adr_i)
      2'd0:    rd_mux = 8'h00;
      2'd1:    rd_mux = rx_full ? rx_data : 8'h00;
      2'd2:    rd_mux = status;
      2'd3:    rd_mux = ctrl_rd;
      default: rd_mux = 8'h00;
    endcase
  end

  // Wishbone acknowledge and registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= rd ? rd_mux : 8'h00;
    end
  end

  // FIFO storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (tx_push) mem[wr_ptr] <= wb_dat_i;
  end

  // FIFO pointers and fill count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (tx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (tx_push && !tx_pop)      count <= count + CNT_ONE;
      else if (tx_pop && !tx_push) count <= count - CNT_ONE;
    end
  end

  // TX FSM state register and the byte latched for UartTop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      uart_tx_data <= 8'h00;
    end else begin
      state <= state_n;
      if (tx_pop) uart_tx_data <= mem[rd_ptr];
    end
  end

  // TX FSM next state; valid is gated by busy so it falls on acceptance
  always_comb begin
    state_n       = state;
    tx_pop        = 1'b0;
    uart_tx_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          state_n = S_PRESENT;
        end
      end
      S_PRESENT: begin
        uart_tx_valid = uart_tx_busy;
        if (!uart_tx_busy) state_n = S_GAP;
      end
      S_GAP:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // RX holding register; a same-cycle pop makes room for the new byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_full <= 1'b0;
      rx_data <= 8'h00;
    end else if (uart_rx_valid) begin
      rx_full <= 1'b1;
      rx_data <= uart_rx_data;
    end else if (rx_pop) begin
      rx_full <= 1'b0;
    end
  end

  // Sticky error flags; a new event wins over a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (uart_rx_valid && rx_full && !rx_pop) rx_overrun <= 1'b1;
      else if (ctrl_wr && wb_dat_i[0])         rx_overrun <= 1'b0;
      if (tx_push_req && tx_full)              tx_overflow <= 1'b1;
      else if (ctrl_wr && wb_dat_i[1])         tx_overflow <= 1'b0;
    end
  end

`ifdef WB_UART_IRQ_EN
  logic irq_en_rx, irq_en_tx;

  assign ctrl_rd = {6'b0, irq_en_rx, irq_en_tx};

  // Interrupt enables loaded on every CTRL write; irq output registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_rx <= 1'b0;
      irq_en_tx <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en_tx <= wb_dat_i[2];
        irq_en_rx <= wb_dat_i[3];
      end
      irq <= (irq_en_rx & rx_full) | (irq_en_tx & tx_empty & ~tx_active) |
             rx_overrun | tx_overflow;
    end
  end
`else
  assign ctrl_rd = 8'h00;
`endif

endmodule

// File: tb/tb_wb_uart_bridge.sv
// Testbench for wb_uart_bridge: bus driver tasks, a UartTop TX stub,
// queue-based scoreboards for bus reads and transmitted bytes, final report.
module tb_wb_uart_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       wb_cyc, wb_stb, wb_we;
  logic [1:0] wb_adr;
  logic [7:0] wb_dat_w;
  logic [7:0] wb_dat_r;
  logic       wb_ack;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid;
  logic       uart_tx_busy;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic [1:0] dbg_tx_state;
`ifdef WB_UART_IRQ_EN
  logic       irq;
`endif

  int total = 0;
  int bad   = 0;
  int tx_accepts = 0;
  logic stub_release = 1'b0;

  logic [8:0] bus_exp_q[$];   // {check_data, expected_read_data}
  logic [7:0] tx_exp_q[$];

  wb_uart_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .wb_cyc_i     (wb_cyc),
    .wb_stb_i     (wb_stb),
    .wb_we_i      (wb_we),
    .wb_adr_i     (wb_adr),
    .wb_dat_i     (wb_dat_w),
    .wb_dat_o     (wb_dat_r),
    .wb_ack_o     (wb_ack),
    .uart_tx_data (uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_busy (uart_tx_busy),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
`ifdef WB_UART_IRQ_EN
    .irq          (irq),
`endif
    .dbg_tx_state (dbg_tx_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus access; optionally pulses uart_rx_valid in the request cycle
  task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                         input logic chk, input logic [7:0] exp,
                         input logic rx_inj, input logic [7:0] rx_byte);
    int n;
    bus_exp_q.push_back({chk, exp});
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = dat;
    if (rx_inj) begin
      uart_rx_valid = 1'b1;
      uart_rx_data  = rx_byte;
    end
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
    check("ack_latency", wb_ack, 1'b1);
    n = 0;
    while (!wb_ack && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    check("ack_single_cycle", wb_ack, 1'b0);
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [7:0] dat);
    wb_xfer(1'b1, adr, dat, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic wb_read(input logic [1:0] adr, input logic [7:0] exp);
    wb_xfer(1'b0, adr, 8'h00, 1'b1, exp, 1'b0, 8'h00);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((tx_exp_q.size() != 0 || dbg_tx_state != 2'd0) && n < 2000) begin
      tick(1);
      n++;
    end
    check("tx_drained", tx_exp_q.size(), 0);
  endtask

  // Bus monitor: every ack pops one expected entry
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst && wb_ack) begin
        if (bus_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got ack with empty expected queue, required no ack");
        end else begin
          e = bus_exp_q.pop_front();
          if (e[8]) check("rd_data", wb_dat_r, e[7:0]);
        end
      end
    end
  end

  // UartTop stub: busy held high; when released, accept one byte by
  // dropping busy for a single cycle, checking the byte against the queue
  initial begin
    uart_tx_busy = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && stub_release && uart_tx_valid) begin
        if (tx_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_tx: got byte 0x%0h with empty expected queue", uart_tx_data);
        end else begin
          check("tx_byte", uart_tx_data, tx_exp_q.pop_front());
        end
        tx_accepts++;
        uart_tx_busy = 1'b0;
        #1;
        check("tx_valid_gated", uart_tx_valid, 1'b0);
        @(negedge clk);
        uart_tx_busy = 1'b1;
      end
    end
  end

  // Directed stimulus
  initial begin
    rst = 1'b1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 2'd0; wb_dat_w = 8'h00;
    uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
    tick(3);
    check("rst_ack", wb_ack, 1'b0);
    check("rst_dat", wb_dat_r, 8'h00);
    check("rst_tx_valid", uart_tx_valid, 1'b0);
    check("rst_tx_data", uart_tx_data, 8'h00);
    check("rst_state", dbg_tx_state, 2'd0);
`ifdef WB_UART_IRQ_EN
    check("rst_irq", irq, 1'b0);
`endif
    rst = 1'b0;
    tick(2);

    // Register reads after reset
    wb_read(2'd2, 8'h02);
    wb_read(2'd3, 8'h00);
    wb_read(2'd0, 8'h00);
    wb_read(2'd1, 8'h00);

    // Held strobe: ack on every second cycle, two accesses
    bus_exp_q.push_back({1'b1, 8'h02});
    bus_exp_q.push_back({1'b1, 8'h02});
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("held_stb_ack", wb_ack, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    tick(1);

    // Single byte through the handshake
    tx_exp_q.push_back(8'h55);
    wb_write(2'd0, 8'h55);
    tick(3);
    check("present_valid", uart_tx_valid, 1'b1);
    check("present_data", uart_tx_data, 8'h55);
    check("present_state", dbg_tx_state, 2'd1);
    wb_read(2'd2, 8'h22);
    stub_release = 1'b1;
    wait_drain();
    stub_release = 1'b0;
    check("one_accept", tx_accepts, 1);
    wb_read(2'd2, 8'h02);

    // Fill: 1 in PRESENT + 16 buffered, then an overflowing write
    for (int i = 0; i <= 16; i++) begin
      tx_exp_q.push_back(8'(i));
      wb_write(2'd0, 8'(i));
    end
    wb_read(2'd2, 8'h21);
    wb_write(2'd0, 8'h11);
    wb_read(2'd2, 8'h31);
    wb_write(2'd3, 8'h02);
    wb_read(2'd2, 8'h21);
    stub_release = 1'b1;
    wait_drain();
    stub_release = 1'b0;
    check("fill_accepts", tx_accepts, 18);
    wb_read(2'd2, 8'h02);

    // RX single byte
    rx_pulse(8'hA3);
    wb_read(2'd2, 8'h06);
    wb_read(2'd1, 8'hA3);
    wb_read(2'd2, 8'h02);
    wb_read(2'd1, 8'h00);

    // RX overrun and clear
    rx_pulse(8'h11);
    tick(1);
    rx_pulse(8'h22);
    wb_read(2'd2, 8'h0E);
    wb_read(2'd1, 8'h22);
    wb_read(2'd2, 8'h0A);
    wb_write(2'd3, 8'h01);
    wb_read(2'd2, 8'h02);

    // Same-cycle pop and new byte: no overrun, new byte held
    rx_pulse(8'h44);
    wb_xfer(1'b0, 2'd1, 8'h00, 1'b1, 8'h44, 1'b1, 8'h99);
    wb_read(2'd2, 8'h06);
    wb_read(2'd1, 8'h99);
    wb_read(2'd2, 8'h02);

`ifdef WB_UART_IRQ_EN
    // RX interrupt enable
    check("irq_idle", irq, 1'b0);
    wb_write(2'd3, 8'h08);
    wb_read(2'd3, 8'h02);
    rx_pulse(8'h5A);
    check("irq_before_latency", irq, 1'b0);
    tick(1);
    check("irq_set", irq, 1'b1);
    wb_read(2'd1, 8'h5A);
    check("irq_clear", irq, 1'b0);
    wb_write(2'd3, 8'h00);
    wb_read(2'd3, 8'h00);
`else
    // Enable bits are absent: CTRL stays 0x00
    wb_write(2'd3, 8'h0C);
    wb_read(2'd3, 8'h00);
`endif

    tick(5);
    check("bus_queue_empty", bus_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
